// File: rtl/uop_pkg.sv
// Shared types and sizing for the uop dispatch slice.
package uop_pkg;

  localparam int INSTR_Q_WIDTH  = 2;
  localparam int INSTR_Q_DEPTH  = 8;
  localparam int DISPATCH_WIDTH = 2;
  localparam int NUM_RS         = 4;
  localparam int ROB_DEPTH      = 32;
  localparam int RETIRE_WIDTH   = 2;
  localparam int RS_SEL_W       = $clog2(NUM_RS);

  // One micro-op as seen by dispatch; rs_sel picks the reservation station.
  typedef struct packed {
    logic [7:0]          opcode;
    logic [5:0]          dst_tag;
    logic [RS_SEL_W-1:0] rs_sel;
  } uop_insn;

endpackage

// File: rtl/uop_dispatch_rob_credit_counter.sv
// ROB free-slot credit register: credits - dispatched + retired, reloaded
// to ROB_DEPTH on reset or flush (retires arriving during a flush are dropped).
module rob_credit_counter
  import uop_pkg::*;
#(
  parameter int ROB_DEPTH = uop_pkg::ROB_DEPTH,
  parameter int DEQ_W     = 2,
  parameter int RET_W     = 2
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic                           flush_in,
  input  logic [DEQ_W-1:0]               deq_in,
  input  logic [RET_W-1:0]               retire_in,
  output logic [$clog2(ROB_DEPTH+1)-1:0] credits_out
);

  localparam int CRED_W = $clog2(ROB_DEPTH+1);
  localparam int SUM_W  = CRED_W + 2;

  logic [SUM_W-1:0] credits_next_s;

  // Full-width update; the extra bits expose any over/underflow to the checker.
  always_comb begin
    credits_next_s = SUM_W'(credits_out) + SUM_W'(retire_in) - SUM_W'(deq_in);
  end

  // Credit register with reset/flush reload.
  always_ff @(posedge clk_in) begin
    if (rst_in || flush_in) begin
      credits_out <= CRED_W'(ROB_DEPTH);
    end else begin
      credits_out <= credits_next_s[CRED_W-1:0];
    end
  end

  rob_credit_counter_chk #(
    .ROB_DEPTH (ROB_DEPTH),
    .CRED_W    (CRED_W),
    .SUM_W     (SUM_W)
  ) u_chk (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .flush_in   (flush_in),
    .credits_in (credits_out),
    .next_in    (credits_next_s)
  );

endmodule

// Credits must never exceed the ROB size, before or after an update.
module rob_credit_counter_chk #(
  parameter int ROB_DEPTH = 32,
  parameter int CRED_W    = 6,
  parameter int SUM_W     = 8
) (
  input logic              clk_in,
  input logic              rst_in,
  input logic              flush_in,
  input logic [CRED_W-1:0] credits_in,
  input logic [SUM_W-1:0]  next_in
);

  a_credits_bound : assert property (@(posedge clk_in) disable iff (rst_in)
    credits_in <= CRED_W'(ROB_DEPTH));

  a_next_bound : assert property (@(posedge clk_in) disable iff (rst_in || flush_in)
    next_in <= SUM_W'(ROB_DEPTH));

endmodule

// File: rtl/uop_dispatch.sv
// In-order dispatch: grants a contiguous prefix of the queue head window
// limited by occupancy, ROB credits and RS readiness/conflicts.
// Optional macro DISPATCH_STATS_EN adds dispatch/stall statistic counters.
module uop_dispatch
  import uop_pkg::*;
#(
  parameter int Q_WIDTH        = uop_pkg::INSTR_Q_WIDTH,
  parameter int Q_DEPTH        = uop_pkg::INSTR_Q_DEPTH,
  parameter int DISPATCH_WIDTH = uop_pkg::DISPATCH_WIDTH,
  parameter int NUM_RS         = uop_pkg::NUM_RS,
  parameter int ROB_DEPTH      = uop_pkg::ROB_DEPTH,
  parameter int RETIRE_WIDTH   = uop_pkg::RETIRE_WIDTH
) (
  input  logic                              clk_in,
  input  logic                              rst_in,
  input  logic                              flush_in,
  input  uop_insn [Q_WIDTH-1:0]             q_in,
  input  logic [$clog2(Q_DEPTH+1)-1:0]      q_size_in,
  output logic [$clog2(Q_WIDTH+1)-1:0]      deq_out,
  input  logic [$clog2(RETIRE_WIDTH+1)-1:0] rob_retire_in,
  input  logic [NUM_RS-1:0]                 rs_ready_in,
  output logic [NUM_RS-1:0]                 rs_valid_out,
  output uop_insn [NUM_RS-1:0]              rs_uop_out,
  output logic [DISPATCH_WIDTH-1:0]         rob_valid_out,
  output uop_insn [DISPATCH_WIDTH-1:0]      rob_uop_out,
  output logic [$clog2(ROB_DEPTH+1)-1:0]    credits_out
`ifdef DISPATCH_STATS_EN
  ,
  output logic [31:0]                       stat_dispatched_out,
  output logic [31:0]                       stat_rob_stall_out,
  output logic [31:0]                       stat_rs_stall_out
`endif
);

  localparam int QS_W   = $clog2(Q_DEPTH+1);
  localparam int DEQ_W  = $clog2(Q_WIDTH+1);
  localparam int CRED_W = $clog2(ROB_DEPTH+1);
  localparam int RET_W  = $clog2(RETIRE_WIDTH+1);

  logic [DISPATCH_WIDTH-1:0]    grant_s;
  logic [NUM_RS-1:0]            rs_claim_s;
  uop_insn [DISPATCH_WIDTH-1:0] rob_uop_s;
  uop_insn [NUM_RS-1:0]         rs_uop_s;
  logic [DEQ_W-1:0]             grant_cnt_s;
  logic                         scan_stop_s;
`ifdef DISPATCH_STATS_EN
  logic                         rob_stall_s;
  logic                         rs_stall_s;
`endif

  // In-order grant scan; the first failing slot blocks all younger slots.
  always_comb begin
    grant_s     = '0;
    rs_claim_s  = '0;
    rob_uop_s   = '0;
    rs_uop_s    = '0;
    grant_cnt_s = '0;
    scan_stop_s = 1'b0;
`ifdef DISPATCH_STATS_EN
    rob_stall_s = 1'b0;
    rs_stall_s  = 1'b0;
`endif
    for (int i = 0; i < DISPATCH_WIDTH; i++) begin
      if (scan_stop_s) begin
        scan_stop_s = 1'b1;
      end else if (q_size_in <= QS_W'(i)) begin
        scan_stop_s = 1'b1;
      end else if (credits_out <= CRED_W'(i)) begin
        scan_stop_s = 1'b1;
`ifdef DISPATCH_STATS_EN
        rob_stall_s = 1'b1;
`endif
      end else if (!rs_ready_in[q_in[i].rs_sel] || rs_claim_s[q_in[i].rs_sel]) begin
        scan_stop_s = 1'b1;
`ifdef DISPATCH_STATS_EN
        rs_stall_s  = 1'b1;
`endif
      end else begin
        grant_s[i]                  = 1'b1;
        rob_uop_s[i]                = q_in[i];
        rs_claim_s[q_in[i].rs_sel]  = 1'b1;
        rs_uop_s[q_in[i].rs_sel]    = q_in[i];
        grant_cnt_s                 = grant_cnt_s + DEQ_W'(1);
      end
    end
  end

  // Dequeue count seen by the queue this cycle; nothing leaves during reset/flush.
  always_comb begin
    if (rst_in || flush_in) begin
      deq_out = '0;
    end else begin
      deq_out = grant_cnt_s;
    end
  end

  // One-cycle dispatch register toward the ROB and reservation stations.
  always_ff @(posedge clk_in) begin
    if (rst_in || flush_in) begin
      rob_valid_out <= '0;
      rob_uop_out   <= '0;
      rs_valid_out  <= '0;
      rs_uop_out    <= '0;
    end else begin
      rob_valid_out <= grant_s;
      rob_uop_out   <= rob_uop_s;
      rs_valid_out  <= rs_claim_s;
      rs_uop_out    <= rs_uop_s;
    end
  end

  rob_credit_counter #(
    .ROB_DEPTH (ROB_DEPTH),
    .DEQ_W     (DEQ_W),
    .RET_W     (RET_W)
  ) u_credits (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .flush_in    (flush_in),
    .deq_in      (deq_out),
    .retire_in   (rob_retire_in),
    .credits_out (credits_out)
  );

`ifdef DISPATCH_STATS_EN
  // Wrapping statistics: uops dispatched, credit stalls, RS stalls.
  always_ff @(posedge clk_in) begin
    if (rst_in || flush_in) begin
      stat_dispatched_out <= 32'd0;
      stat_rob_stall_out  <= 32'd0;
      stat_rs_stall_out   <= 32'd0;
    end else begin
      stat_dispatched_out <= stat_dispatched_out + 32'(grant_cnt_s);
      stat_rob_stall_out  <= stat_rob_stall_out + (rob_stall_s ? 32'd1 : 32'd0);
      stat_rs_stall_out   <= stat_rs_stall_out + (rs_stall_s ? 32'd1 : 32'd0);
    end
  end
`endif

endmodule

// File: tb/tb_uop_dispatch.sv
// Self-checking bench for uop_dispatch: directed test-plan steps followed by
// randomized cycles, all checked against a behavioural model of the grant rules.
module tb_uop_dispatch;
  import uop_pkg::*;

  localparam int QW    = INSTR_Q_WIDTH;
  localparam int QD    = INSTR_Q_DEPTH;
  localparam int DW    = DISPATCH_WIDTH;
  localparam int NRS   = NUM_RS;
  localparam int QSW   = $clog2(QD+1);
  localparam int DEQW  = $clog2(QW+1);
  localparam int RETW  = $clog2(RETIRE_WIDTH+1);
  localparam int CREDW = $clog2(ROB_DEPTH+1);

  logic                 clk_in = 1'b0;
  logic                 rst_in;
  logic                 flush_in;
  uop_insn [QW-1:0]     q_in;
  logic [QSW-1:0]       q_size_in;
  logic [DEQW-1:0]      deq_out;
  logic [RETW-1:0]      rob_retire_in;
  logic [NRS-1:0]       rs_ready_in;
  logic [NRS-1:0]       rs_valid_out;
  uop_insn [NRS-1:0]    rs_uop_out;
  logic [DW-1:0]        rob_valid_out;
  uop_insn [DW-1:0]     rob_uop_out;
  logic [CREDW-1:0]     credits_out;
`ifdef DISPATCH_STATS_EN
  logic [31:0]          stat_dispatched_out;
  logic [31:0]          stat_rob_stall_out;
  logic [31:0]          stat_rs_stall_out;
  int                   m_disp, m_robst, m_rsst;
  int                   rs_before;
`endif

  int tests = 0;
  int fails = 0;
  int m_credits;
  int obs_deq;

  always #5 clk_in = ~clk_in;

  uop_dispatch dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .flush_in      (flush_in),
    .q_in          (q_in),
    .q_size_in     (q_size_in),
    .deq_out       (deq_out),
    .rob_retire_in (rob_retire_in),
    .rs_ready_in   (rs_ready_in),
    .rs_valid_out  (rs_valid_out),
    .rs_uop_out    (rs_uop_out),
    .rob_valid_out (rob_valid_out),
    .rob_uop_out   (rob_uop_out),
    .credits_out   (credits_out)
`ifdef DISPATCH_STATS_EN
    ,
    .stat_dispatched_out (stat_dispatched_out),
    .stat_rob_stall_out  (stat_rob_stall_out),
    .stat_rs_stall_out   (stat_rs_stall_out)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Load the head window with given RS selects and random payloads.
  task automatic set_q(input int s0, input int s1);
    q_in[0].opcode  = 8'($urandom);
    q_in[0].dst_tag = 6'($urandom);
    q_in[0].rs_sel  = RS_SEL_W'(s0);
    q_in[1].opcode  = 8'($urandom);
    q_in[1].dst_tag = 6'($urandom);
    q_in[1].rs_sel  = RS_SEL_W'(s1);
  endtask

  // One clock: drive inputs, check deq_out, then check registered results.
  task automatic step(input logic rst, input logic fl, input int qs,
                      input logic [NRS-1:0] rdy, input int ret);
    int n, lim, sel, ecred;
    logic [NRS-1:0]    taken;
    logic [DW-1:0]     erv;
    logic [NRS-1:0]    esv;
    uop_insn [DW-1:0]  eru;
    uop_insn [NRS-1:0] esu;
    rst_in = rst; flush_in = fl; q_size_in = QSW'(qs);
    rs_ready_in = rdy; rob_retire_in = RETW'(ret);
    #1;
    n = 0; taken = '0; erv = '0; esv = '0; eru = '0; esu = '0;
    if (!rst && !fl) begin
      lim = DW;
      if (qs < lim) lim = qs;
      if (m_credits < lim) lim = m_credits;
      while (n < lim) begin
        sel = int'(q_in[n].rs_sel);
        if (!rdy[sel] || taken[sel]) break;
        taken[sel] = 1'b1;
        erv[n] = 1'b1; eru[n] = q_in[n];
        esv[sel] = 1'b1; esu[sel] = q_in[n];
        n++;
      end
    end
    chk("deq_out", 64'(deq_out), 64'(n));
    obs_deq = int'(deq_out);
    ecred = (rst || fl) ? ROB_DEPTH : m_credits - n + ret;
`ifdef DISPATCH_STATS_EN
    if (rst || fl) begin
      m_disp = 0; m_robst = 0; m_rsst = 0;
    end else begin
      m_disp += n;
      if (n < DW && n < qs && n == m_credits) m_robst++;
      else if (n < DW && n < qs) m_rsst++;
    end
`endif
    @(posedge clk_in); #1;
    chk("rob_valid", 64'(rob_valid_out), 64'(erv));
    chk("rob_uop",   64'(rob_uop_out),   64'(eru));
    chk("rs_valid",  64'(rs_valid_out),  64'(esv));
    chk("rs_uop",    64'(rs_uop_out),    64'(esu));
    chk("credits",   64'(credits_out),   64'(ecred));
`ifdef DISPATCH_STATS_EN
    chk("stat_disp",  64'(stat_dispatched_out), 64'(m_disp));
    chk("stat_rob",   64'(stat_rob_stall_out),  64'(m_robst));
    chk("stat_rs",    64'(stat_rs_stall_out),   64'(m_rsst));
`endif
    m_credits = ecred;
    @(negedge clk_in);
  endtask

  initial begin
    int k, r, ret_max;
    rst_in = 1'b1; flush_in = 1'b0; q_size_in = '0;
    rob_retire_in = '0; rs_ready_in = '0;
    set_q(0, 1);
    m_credits = ROB_DEPTH;
`ifdef DISPATCH_STATS_EN
    m_disp = 0; m_robst = 0; m_rsst = 0;
`endif
    @(negedge clk_in);

    // Reset state, including reset with a populated queue.
    step(1'b1, 1'b0, 0, 4'hF, 0);
    chk("rst_credits", 64'(credits_out), 64'd32);
    step(1'b1, 1'b0, 5, 4'hF, 0);
    chk("rst_deq", 64'(obs_deq), 64'd0);
    chk("rst_valid", 64'({rob_valid_out, rs_valid_out}), 64'd0);

    // Two independent RS targets: full-width dispatch.
    set_q(0, 1);
    step(1'b0, 1'b0, 5, 4'b1111, 0);
    chk("tp1_deq", 64'(obs_deq), 64'd2);
    chk("tp1_rob_valid", 64'(rob_valid_out), 64'b11);
    chk("tp1_rs_valid", 64'(rs_valid_out), 64'b0011);
    chk("tp1_credits", 64'(credits_out), 64'd30);

    // RS conflict: both slots target RS 2.
    set_q(2, 2);
    step(1'b0, 1'b0, 5, 4'hF, 0);
    chk("tp2_deq", 64'(obs_deq), 64'd1);
    chk("tp2_rob_valid", 64'(rob_valid_out), 64'b01);

    // Oldest uop targets a not-ready RS.
`ifdef DISPATCH_STATS_EN
    rs_before = int'(stat_rs_stall_out);
`endif
    set_q(1, 0);
    step(1'b0, 1'b0, 5, 4'b1101, 0);
    chk("tp3_deq", 64'(obs_deq), 64'd0);
`ifdef DISPATCH_STATS_EN
    chk("tp3_rs_stall_inc", 64'(stat_rs_stall_out), 64'(rs_before + 1));
`endif

    // Drain credits down to 1.
    set_q(0, 1);
    k = 0;
    while (m_credits > 1 && k < 40) begin
      step(1'b0, 1'b0, 5, 4'hF, 0);
      k++;
    end
    chk("drain_credits", 64'(credits_out), 64'd1);
    step(1'b0, 1'b0, 3, 4'hF, 0);
    chk("cred1_deq", 64'(obs_deq), 64'd1);
    chk("cred0_credits", 64'(credits_out), 64'd0);
    step(1'b0, 1'b0, 3, 4'hF, 0);
    chk("cred0_deq", 64'(obs_deq), 64'd0);
    step(1'b0, 1'b0, 3, 4'hF, 2);
    chk("retire_same_cycle_deq", 64'(obs_deq), 64'd0);
    chk("retire_credits", 64'(credits_out), 64'd2);
    step(1'b0, 1'b0, 3, 4'hF, 0);
    chk("resume_deq", 64'(obs_deq), 64'd2);

    // Refill to 10 credits, then flush with retires in flight.
    for (int j = 0; j < 5; j++) step(1'b0, 1'b0, 0, 4'hF, 2);
    chk("refill_credits", 64'(credits_out), 64'd10);
    step(1'b0, 1'b1, 4, 4'hF, 2);
    chk("flush_deq", 64'(obs_deq), 64'd0);
    chk("flush_valid", 64'({rob_valid_out, rs_valid_out}), 64'd0);
    chk("flush_credits", 64'(credits_out), 64'd32);

    // Single queued uop.
    set_q(3, 0);
    step(1'b0, 1'b0, 1, 4'hF, 0);
    chk("q1_deq", 64'(obs_deq), 64'd1);
    chk("q1_rob_valid", 64'(rob_valid_out), 64'b01);

    // Reset in the middle of traffic behaves like flush.
    set_q(0, 1);
    step(1'b0, 1'b0, 4, 4'hF, 0);
    step(1'b1, 1'b0, 4, 4'hF, 1);
    chk("midrst_valid", 64'({rob_valid_out, rs_valid_out}), 64'd0);
    chk("midrst_credits", 64'(credits_out), 64'd32);

    // Randomized traffic.
    for (int j = 0; j < 400; j++) begin
      set_q(int'($urandom_range(0, NRS-1)), int'($urandom_range(0, NRS-1)));
      ret_max = ROB_DEPTH - m_credits;
      if (ret_max > RETIRE_WIDTH) ret_max = RETIRE_WIDTH;
      r = int'($urandom_range(0, ret_max));
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 31) == 0),
           int'($urandom_range(0, QD)), NRS'($urandom), r);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uop_dispatch.md
# uop_dispatch

In-order dispatch stage draining the instruction queue. Each cycle it inspects the queue head window and computes how many uops can leave. The count is limited by queue occupancy, ROB free-slot credits and reservation-station readiness. It drives the queue's dequeue count combinationally and registers the granted uops toward the ROB and the reservation stations (RS).

## Interface
Parameters:
- Q_WIDTH, uop_pkg::INSTR_Q_WIDTH: queue head window width.
- Q_DEPTH, uop_pkg::INSTR_Q_DEPTH: queue depth; sets size width.
- DISPATCH_WIDTH, uop_pkg::DISPATCH_WIDTH (2): max uops per cycle; must be ≤ Q_WIDTH.
- NUM_RS, uop_pkg::NUM_RS (4): reservation stations, one uop each per cycle.
- ROB_DEPTH, uop_pkg::ROB_DEPTH (32): credit counter reset value.
- RETIRE_WIDTH, uop_pkg::RETIRE_WIDTH (2): max ROB retires per cycle.

Ports:
- clk_in  in  1  clock.
- rst_in  in  1  synchronous, active-high reset.
- flush_in  in  1  pipeline flush.
- q_in  in  uop_insn[Q_WIDTH]  queue head window; slot 0 is oldest.
- q_size_in  in  $clog2(Q_DEPTH+1)  valid entries in queue.
- deq_out  out  $clog2(Q_WIDTH+1)  uops granted this cycle.
- rob_retire_in  in  $clog2(RETIRE_WIDTH+1)  ROB entries freed this cycle.
- rs_ready_in  in  NUM_RS  RS k can take one uop next cycle.
- rs_valid_out  out  NUM_RS  registered per-RS valid.
- rs_uop_out  out  uop_insn[NUM_RS]  registered per-RS uop.
- rob_valid_out  out  DISPATCH_WIDTH  registered per-slot ROB allocate valid, contiguous from slot 0.
- rob_uop_out  out  uop_insn[DISPATCH_WIDTH]  registered uops in program order.
- credits_out  out  $clog2(ROB_DEPTH+1)  current free ROB credits.

## Operation
Grant scan (combinational), for slot i = 0..DISPATCH_WIDTH-1:
- Slot i is granted only if every earlier slot was granted.
- It also needs i < q_size_in, i < credits, and rs_ready_in[q_in[i].rs_sel] high.
- Its RS must not be claimed by an earlier slot this cycle.
- The first failing slot stops the scan; deq_out is the number of granted slots.

Forcing and updates:
- deq_out is forced to 0 while rst_in or flush_in is high.
- Granted uop i is registered to rob_uop_out[i] / rob_valid_out[i] and to rs_uop_out[rs_sel] / rs_valid_out[rs_sel]. Ungranted valids register 0.
- Credits update as credits_next = credits − deq_out + rob_retire_in, evaluated at full width with no wrap.
- Grants use only the current credit value; a retire in the same cycle is visible next cycle.
- Flush: all registered valids clear next cycle, credits reload to ROB_DEPTH, and in-flight retires that cycle are ignored.
- Reset: every valid output is 0, all uop outputs are '0, credits = ROB_DEPTH, deq_out = 0.

## Timing
- deq_out is combinational from q_in, q_size_in, credits and rs_ready_in. The queue consumes it at the same posedge.
- Dispatch latency is one cycle: a uop granted in cycle N is valid on rs_*/rob_* outputs in cycle N+1 for exactly one cycle. There is no hold; the RS must accept it because ready was asserted.
- credits_out is registered and reflects the cycle-N grants and retires in cycle N+1.
- Queue empty (q_size_in=0) or credits=0 gives deq_out=0 and no valids next cycle.
- Reset asserted mid-stream drops pending outputs at the next edge, identical to flush.

## Configuration
- DISPATCH_STATS_EN defined: adds three 32-bit wrapping counters, each cleared on rst_in or flush_in.
  - stat_dispatched_out: sum of deq_out.
  - stat_rob_stall_out: cycles where the scan stopped on credits with q_size_in>0.
  - stat_rs_stall_out: cycles where it stopped on RS ready or an RS conflict.
- Undefined: these ports and counters do not exist; dispatch behaviour is identical.

## Structure
- uop_pkg holds DISPATCH_WIDTH, NUM_RS, ROB_DEPTH and RETIRE_WIDTH.
- uop_insn gains an rs_sel field, $clog2(NUM_RS) bits.
- Sub-module rob_credit_counter owns the credit register, update arithmetic, flush reload and an overflow assertion (credits ≤ ROB_DEPTH).

## Test plan
- Reset, then q_size_in=5 with rs_sel 0,1 and all RS ready: deq_out=2; next cycle rob_valid_out=2'b11, rs_valid_out=4'b0011, credits_out=30.
- rs_sel 2,2: deq_out=1; only slot 0 dispatched.
- rs_ready_in=4'b1101 with slot 0 rs_sel=1: deq_out=0, rs stall counter +1 with DISPATCH_STATS_EN.
- Drain to credits=1 with 3 uops queued: deq_out=1; next cycle credits_out=0 and deq_out=0. Then rob_retire_in=2: credits_out=2 one cycle later, dispatch resumes.
- Flush with q_size_in=4 and credits=10: deq_out=0, next cycle all valids 0 and credits_out=32.
- q_size_in=1 with DISPATCH_WIDTH=2: deq_out=1 and rob_valid_out=2'b01.
